// File: rtl/vmem_text_writer_if.sv
// Character-in / vmem-write-out bus for vmem_text_writer.
// master = character producer and vmem consumer side, slave = the writer itself.
interface vmem_text_writer_if;
  logic        in_valid;
  logic [7:0]  in_ascii;
  logic        in_ready;
  logic        we;
  logic [11:0] waddr;
  logic [7:0]  wdata;

  modport master (
    output in_valid, in_ascii,
    input  in_ready, we, waddr, wdata
  );

  modport slave (
    input  in_valid, in_ascii,
    output in_ready, we, waddr, wdata
  );
endinterface

// File: rtl/vmem_text_writer.sv
// ASCII stream to text-mode vmem writer: cursor, wrap, backspace, hardware scroll via row_base.
// Optional feature macro: VMEM_TAB_EN (0x09 advances to the next 8-column stop).
module vmem_text_writer #(
  parameter int COLS  = 70,
  parameter int ROWS  = 30,
  parameter int PROWS = 32,
  parameter int COL_W = 7,
  parameter int ROW_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  vmem_text_writer_if.slave  io,
  output logic [COL_W-1:0]   cur_col,
  output logic [ROW_W-1:0]   cur_row,
  output logic [ROW_W-1:0]   row_base,
  output logic               busy
);

  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] LAST_PROW = ROW_W'(PROWS - 1);
  localparam logic [7:0]       SPACE     = 8'h20;

  typedef enum logic [1:0] {INIT_CLR, IDLE, SCROLL_CLR} state_t;
  state_t state;

  logic [COL_W-1:0] clr_col;
  logic [ROW_W-1:0] clr_row;

  logic [ROW_W-1:0] prow;
  logic [ROW_W-1:0] scroll_prow;
  logic             wr_en;
  logic [COL_W-1:0] wr_col;
  logic [ROW_W-1:0] wr_prow;
  logic [7:0]       wr_data;
  logic             nl;
  logic             scroll;
  logic [COL_W-1:0] nxt_col;
  logic [ROW_W-1:0] nxt_row;
`ifdef VMEM_TAB_EN
  logic [COL_W-1:0] tab_col;
`endif

  // Character decode for the current in_ascii at the current cursor.
  always_comb begin
    prow        = row_base + cur_row;
    scroll_prow = row_base + ROW_W'(ROWS);
    wr_en       = 1'b0;
    wr_col      = cur_col;
    wr_prow     = prow;
    wr_data     = SPACE;
    nl          = 1'b0;
    nxt_col     = cur_col;
    nxt_row     = cur_row;
`ifdef VMEM_TAB_EN
    tab_col     = (cur_col | COL_W'(7)) + COL_W'(1);
`endif
    if (io.in_ascii >= 8'h20 && io.in_ascii <= 8'h7E) begin
      wr_en   = 1'b1;
      wr_data = io.in_ascii;
      if (cur_col == LAST_COL) nl = 1'b1;
      else                     nxt_col = cur_col + COL_W'(1);
    end else if (io.in_ascii == 8'h0A || io.in_ascii == 8'h0D) begin
      nl = 1'b1;
    end else if (io.in_ascii == 8'h08) begin
      if (cur_col != '0) begin
        wr_en   = 1'b1;
        nxt_col = cur_col - COL_W'(1);
        wr_col  = cur_col - COL_W'(1);
      end else if (cur_row != '0) begin
        wr_en   = 1'b1;
        nxt_col = LAST_COL;
        nxt_row = cur_row - ROW_W'(1);
        wr_col  = LAST_COL;
        wr_prow = row_base + (cur_row - ROW_W'(1));
      end
    end
`ifdef VMEM_TAB_EN
    else if (io.in_ascii == 8'h09) begin
      if (tab_col >= COL_W'(COLS)) nl = 1'b1;
      else                         nxt_col = tab_col;
    end
`endif
    if (nl) begin
      nxt_col = '0;
      if (cur_row != LAST_ROW) nxt_row = cur_row + ROW_W'(1);
    end
    scroll = nl && (cur_row == LAST_ROW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT_CLR;
      io.we       <= 1'b0;
      io.waddr    <= '0;
      io.wdata    <= '0;
      io.in_ready <= 1'b0;
      busy        <= 1'b1;
      cur_col     <= '0;
      cur_row     <= '0;
      row_base    <= '0;
      clr_col     <= '0;
      clr_row     <= '0;
    end else begin
      case (state)
        INIT_CLR: begin
          io.we    <= 1'b1;
          io.waddr <= {clr_col, clr_row};
          io.wdata <= SPACE;
          if (clr_col == LAST_COL) begin
            clr_col <= '0;
            clr_row <= clr_row + ROW_W'(1);
            if (clr_row == LAST_PROW) state <= IDLE;
          end else begin
            clr_col <= clr_col + COL_W'(1);
          end
        end
        IDLE: begin
          // Entered with in_ready low after a clear: spend one cycle re-opening the handshake.
          if (!io.in_ready) begin
            io.in_ready <= 1'b1;
            busy        <= 1'b0;
            io.we       <= 1'b0;
          end else if (io.in_valid) begin
            cur_col <= nxt_col;
            cur_row <= nxt_row;
            if (scroll) begin
              row_base    <= row_base + ROW_W'(1);
              clr_row     <= scroll_prow;
              io.in_ready <= 1'b0;
              busy        <= 1'b1;
              state       <= SCROLL_CLR;
              io.we       <= 1'b1;
              // A pure newline has a free write slot, so the row clear starts immediately.
              if (wr_en) begin
                io.waddr <= {wr_col, wr_prow};
                io.wdata <= wr_data;
                clr_col  <= '0;
              end else begin
                io.waddr <= {COL_W'(0), scroll_prow};
                io.wdata <= SPACE;
                clr_col  <= COL_W'(1);
              end
            end else begin
              io.we    <= wr_en;
              io.waddr <= {wr_col, wr_prow};
              io.wdata <= wr_data;
            end
          end else begin
            io.we <= 1'b0;
          end
        end
        SCROLL_CLR: begin
          io.we    <= 1'b1;
          io.waddr <= {clr_col, clr_row};
          io.wdata <= SPACE;
          if (clr_col == LAST_COL) begin
            clr_col <= '0;
            state   <= IDLE;
          end else begin
            clr_col <= clr_col + COL_W'(1);
          end
        end
        default: state <= INIT_CLR;
      endcase
    end
  end

endmodule

// File: tb/tb_vmem_text_writer.sv
// Directed self-checking bench for vmem_text_writer: init clear, streaming, wrap, backspace, scroll, reset abort.
module tb_vmem_text_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] cur_col;
  logic [4:0] cur_row;
  logic [4:0] row_base;
  logic       busy;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  vmem_text_writer_if bus ();

  vmem_text_writer #(
    .COLS (70),
    .ROWS (30),
    .PROWS(32),
    .COL_W(7),
    .ROW_W(5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .io      (bus.slave),
    .cur_col (cur_col),
    .cur_row (cur_row),
    .row_base(row_base),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one character, wait (bounded) for in_ready, transfer it on the next edge.
  task automatic send(input logic [7:0] c);
    bus.in_valid = 1'b1;
    bus.in_ascii = c;
    for (int i = 0; i < 3000 && !bus.in_ready; i++) tick();
    check("ready_before_send", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  int hits [2240];
  int cnt;
  int bad;
  int missing;
  int exp_tab_col;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_ascii = 8'h00;
    foreach (hits[i]) hits[i] = 0;

    // Reset state
    tick(); tick(); tick();
    check("rst_busy",     32'(busy),         32'd1);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_we",       32'(bus.we),       32'd0);
    check("rst_waddr",    32'(bus.waddr),    32'd0);
    check("rst_wdata",    32'(bus.wdata),    32'd0);
    check("rst_cursor",   {cur_col, cur_row, row_base}, 32'd0);

    // Initial clear: 2240 write cycles of 0x20 covering every address once
    rst = 1'b0;
    cnt = 0;
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (!busy) break;
      cnt++;
      if (!(bus.we === 1'b1 && bus.wdata === 8'h20)) bad++;
      if (bus.waddr < 12'd2240) hits[bus.waddr]++;
      else bad++;
    end
    missing = 0;
    foreach (hits[i]) if (hits[i] != 1) missing++;
    check("init_busy_cycles", 32'(cnt),          32'd2240);
    check("init_bad_writes",  32'(bad),          32'd0);
    check("init_coverage",    32'(missing),      32'd0);
    check("init_in_ready",    32'(bus.in_ready), 32'd1);
    check("init_we_off",      32'(bus.we),       32'd0);

    // 'A','B' back-to-back
    send(8'h41);
    check("A_we",    32'(bus.we),    32'd1);
    check("A_waddr", 32'(bus.waddr), 32'd0);
    check("A_wdata", 32'(bus.wdata), 32'h41);
    check("A_col",   32'(cur_col),   32'd1);
    send(8'h42);
    check("B_we",    32'(bus.we),    32'd1);
    check("B_waddr", 32'(bus.waddr), 32'd32);
    check("B_wdata", 32'(bus.wdata), 32'h42);
    check("B_col",   32'(cur_col),   32'd2);
    tick();
    check("idle_we", 32'(bus.we), 32'd0);

    // Backspace within a row: 0x20 at the new column
    send(8'h08);
    check("bs1_waddr", 32'(bus.waddr), 32'd32);
    check("bs1_wdata", 32'(bus.wdata), 32'h20);
    check("bs1_col",   32'(cur_col),   32'd1);
    send(8'h08);
    check("bs2_cursor", {cur_row, cur_col}, 32'd0);

    // 70 x 'x' wraps; 'y' lands at column 0 of row 1
    for (int i = 0; i < 70; i++) send(8'h78);
    check("x69_waddr",  32'(bus.waddr),       32'd2208);
    check("x69_wdata",  32'(bus.wdata),       32'h78);
    check("wrap_cursor", {cur_row, cur_col},  {5'd1, 7'd0});
    send(8'h79);
    check("y_waddr",  32'(bus.waddr),      32'd1);
    check("y_wdata",  32'(bus.wdata),      32'h79);
    check("y_cursor", {cur_row, cur_col},  {5'd1, 7'd1});

    // Backspace across a row boundary, then at the home position
    send(8'h08);
    check("bs_col0_waddr", 32'(bus.waddr), 32'd1);
    send(8'h08);
    check("bs_up_we",     32'(bus.we),         32'd1);
    check("bs_up_waddr",  32'(bus.waddr),      32'd2208);
    check("bs_up_wdata",  32'(bus.wdata),      32'h20);
    check("bs_up_cursor", {cur_row, cur_col},  {5'd0, 7'd69});
    for (int i = 0; i < 69; i++) send(8'h08);
    check("home_cursor", {cur_row, cur_col}, 32'd0);
    send(8'h08);
    check("bs_home_we",     32'(bus.we),        32'd0);
    check("bs_home_cursor", {cur_row, cur_col}, 32'd0);

    // Tab and discarded codes at column 5
    for (int i = 0; i < 5; i++) send(8'h61);
`ifdef VMEM_TAB_EN
    exp_tab_col = 8;
`else
    exp_tab_col = 5;
`endif
    send(8'h09);
    check("tab_we",  32'(bus.we),  32'd0);
    check("tab_col", 32'(cur_col), 32'(exp_tab_col));
    send(8'h7F);
    check("del_we",  32'(bus.we),  32'd0);
    send(8'hC1);
    check("hi_we",   32'(bus.we),  32'd0);
    check("junk_cursor", {cur_row, cur_col}, {5'd0, 7'(exp_tab_col)});

    // Newlines down to the bottom row
    send(8'h0A);
    check("lf_we",     32'(bus.we),        32'd0);
    check("lf_cursor", {cur_row, cur_col}, {5'd1, 7'd0});
    for (int i = 0; i < 28; i++) send(8'h0D);
    check("bottom_cursor", {cur_row, cur_col}, {5'd29, 7'd0});
    for (int i = 0; i < 5; i++) send(8'h7A);
    check("bottom_z_waddr", 32'(bus.waddr), {20'd0, 7'd4, 5'd29});

    // Scroll: row_base 0->1, 70 cycles of clearing physical row 30
    send(8'h0A);
    cnt = 0;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.in_ready) break;
      if (!(bus.we === 1'b1 && bus.wdata === 8'h20 && bus.waddr === {7'(cnt), 5'd30})) bad++;
      cnt++;
      tick();
    end
    check("scroll_low_cycles", 32'(cnt),      32'd70);
    check("scroll_clear_bad",  32'(bad),      32'd0);
    check("scroll_row_base",   32'(row_base), 32'd1);
    check("scroll_cursor",     {cur_row, cur_col}, {5'd29, 7'd0});
    send(8'h71);
    check("after_scroll_waddr", 32'(bus.waddr), {20'd0, 7'd0, 5'd30});

    // Reset in the middle of a scroll clear
    send(8'h0A);
    for (int i = 0; i < 10; i++) tick();
    check("midscroll_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check("abort_we",     32'(bus.we),       32'd0);
    check("abort_ready",  32'(bus.in_ready), 32'd0);
    check("abort_state",  {busy, cur_row, cur_col, row_base}, {1'b1, 17'd0});
    rst = 1'b0;
    tick();
    check("restart_we",    32'(bus.we),    32'd1);
    check("restart_waddr", 32'(bus.waddr), 32'd0);
    check("restart_wdata", 32'(bus.wdata), 32'h20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
